// File: rtl/dbg_dr_shift.sv
// Debug data-register shifter: SPI bit stream plus shift/update strobes -> parallel debug word.
// Define DBG_DR_SYNC_EN to insert 2-flop synchronizers on the SPI/GPIO inputs.
module dbg_dr_shift #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_sck,
    input  logic             spi_mosi,
    output logic             spi_miso,
    input  logic             shift_dr,
    input  logic             update_dr,
    input  logic [WIDTH-1:0] capture_data,
    output logic [WIDTH-1:0] dr_out,
    output logic             dr_valid,
    output logic             dr_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    // Bit positions of the conditioned input lines.
    localparam int P_SCK   = 3;
    localparam int P_MOSI  = 2;
    localparam int P_SHIFT = 1;
    localparam int P_UPD   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_UPDATE
    } state_t;

    state_t state, state_nxt;

    logic [3:0]       pin_raw;
    logic [3:0]       pin_s;
    logic             sck_q, shift_q, upd_q;
    logic             sck_rise, shift_rise, shift_fall, upd_rise;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bitcnt;

    assign pin_raw = {spi_sck, spi_mosi, shift_dr, update_dr};

`ifdef DBG_DR_SYNC_EN
    logic [3:0] sync_q1, sync_q2;

    // NOTE: synchronizers and edge registers are reset too, so no phantom edge is seen after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= pin_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign pin_s = sync_q2;
`else
    assign pin_s = pin_raw;
`endif

    // NOTE: non-blocking assignments in clocked blocks keep every flop sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q   <= 1'b0;
            shift_q <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            sck_q   <= pin_s[P_SCK];
            shift_q <= pin_s[P_SHIFT];
            upd_q   <= pin_s[P_UPD];
        end
    end

    assign sck_rise   = pin_s[P_SCK] & ~sck_q;
    assign shift_rise = pin_s[P_SHIFT] & ~shift_q;
    assign shift_fall = ~pin_s[P_SHIFT] & shift_q;
    assign upd_rise   = pin_s[P_UPD] & ~upd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // A shift start outranks a simultaneous update, which is then dropped.
                if (shift_rise) begin
                    state_nxt = ST_SHIFT;
                end else if (upd_rise) begin
                    state_nxt = ST_UPDATE;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (shift_fall) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            bitcnt   <= '0;
            dr_out   <= '0;
            dr_valid <= 1'b0;
            dr_err   <= 1'b0;
        end else begin
            dr_valid <= 1'b0;
            dr_err   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (shift_rise) begin
                        shreg  <= capture_data;
                        bitcnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    // A final sck edge coinciding with the shift_dr fall still lands.
                    if (sck_rise) begin
                        shreg <= {shreg[WIDTH-2:0], pin_s[P_MOSI]};
                        if (bitcnt != CNT_FULL) begin
                            bitcnt <= bitcnt + CNT_W'(1);
                        end
                    end
                end
                ST_UPDATE: begin
                    if (bitcnt == CNT_FULL) begin
                        dr_out   <= shreg;
                        dr_valid <= 1'b1;
                    end else begin
                        dr_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign spi_miso = shreg[WIDTH-1];

endmodule

// File: tb/tb_dbg_dr_shift.sv
// Directed bench for dbg_dr_shift: SPI shifts at a 4-5x clock ratio with hand-computed results.
// Latencies follow DBG_DR_SYNC_EN the same way the design does.
module tb_dbg_dr_shift;

`ifdef DBG_DR_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        shift_dr = 1'b0;
    logic        update_dr = 1'b0;
    logic [31:0] capture_data = '0;
    logic [31:0] dr_out;
    logic        dr_valid;
    logic        dr_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_pulses = 0;
    int err_pulses = 0;
    int both_high = 0;
    int busy_cycles = 0;

    dbg_dr_shift #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .shift_dr     (shift_dr),
        .update_dr    (update_dr),
        .capture_data (capture_data),
        .dr_out       (dr_out),
        .dr_valid     (dr_valid),
        .dr_err       (dr_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Pulse bookkeeping, sampled half a period away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (dr_valid) valid_pulses = valid_pulses + 1;
            if (dr_err) err_pulses = err_pulses + 1;
            if (dr_valid && dr_err) both_high = both_high + 1;
            if (busy) busy_cycles = busy_cycles + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_shift(input logic [31:0] cap, input string tag);
        @(negedge clk);
        capture_data = cap;
        spi_sck      = 1'b0;
        shift_dr     = 1'b1;
        repeat (SYNC_LAT) @(negedge clk);
        check({tag, "_busy_early"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_busy_rise"}, 64'(busy), 64'd1);
    endtask

    task automatic shift_bits(input logic [63:0] data, input int nbits, input int upd_bit,
                              output logic [31:0] miso_word);
        miso_word = '0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            spi_mosi = data[nbits-1-i];
            spi_sck  = 1'b0;
            if (i == upd_bit) update_dr = 1'b1;
            repeat (2) @(negedge clk);
            miso_word = {miso_word[30:0], spi_miso};
            spi_sck = 1'b1;
            repeat (2) @(negedge clk);
            if (i == upd_bit) update_dr = 1'b0;
        end
        @(negedge clk);
        spi_sck = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_shift(input string tag);
        shift_dr = 1'b0;
        repeat (SYNC_LAT) @(negedge clk);
        check({tag, "_busy_hold"}, 64'(busy), 64'd1);
        @(negedge clk);
        check({tag, "_busy_fall"}, 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_update(output int v_delta, output int e_delta, output int lat);
        int v0, e0, start;
        v0  = valid_pulses;
        e0  = err_pulses;
        lat = -1;
        @(negedge clk);
        start     = cyc;
        update_dr = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (dr_valid && lat < 0) lat = cyc - start;
        end
        update_dr = 1'b0;
        repeat (SYNC_LAT + 4) @(negedge clk);
        v_delta = valid_pulses - v0;
        e_delta = err_pulses - e0;
    endtask

    initial begin
        logic [31:0] miso_word;
        int v_d, e_d, lat, v0, e0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dr_out", 64'(dr_out), 64'd0);
        check("rst_dr_valid", 64'(dr_valid), 64'd0);
        check("rst_dr_err", 64'(dr_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_miso", 64'(spi_miso), 64'd0);
        rst = 1'b0;

        // Idle: sck toggles with shift_dr low, nothing may happen
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 2 == 0) spi_sck = ~spi_sck;
            spi_mosi = 1'($urandom_range(0, 1));
        end
        spi_sck = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_valid", 64'(valid_pulses), 64'd0);
        check("idle_err", 64'(err_pulses), 64'd0);
        check("idle_busy", 64'(busy_cycles), 64'd0);
        check("idle_dr_out", 64'(dr_out), 64'd0);

        // Full 32-bit shift with capture readback
        start_shift(32'hCAFE_F00D, "full");
        shift_bits(64'h0000_0000_1234_5678, 32, -1, miso_word);
        check("full_miso_word", 64'(miso_word), 64'hCAFE_F00D);
        end_shift("full");
        do_update(v_d, e_d, lat);
        check("full_dr_out", 64'(dr_out), 64'h1234_5678);
        check("full_valid_cnt", 64'(v_d), 64'd1);
        check("full_err_cnt", 64'(e_d), 64'd0);
        check("full_valid_lat", 64'(lat), 64'(SYNC_LAT + 2));

        // Short shift: 31 bits must be rejected
        start_shift(32'h0, "short");
        shift_bits(64'h0000_0000_0BAD_C0DE, 31, -1, miso_word);
        end_shift("short");
        do_update(v_d, e_d, lat);
        check("short_err_cnt", 64'(e_d), 64'd1);
        check("short_valid_cnt", 64'(v_d), 64'd0);
        check("short_dr_out_hold", 64'(dr_out), 64'h1234_5678);

        // Over-length shift: last 32 of 40 bits commit
        start_shift(32'h5555_AAAA, "long");
        shift_bits(64'h0000_00AA_DEAD_BEEF, 40, -1, miso_word);
        end_shift("long");
        do_update(v_d, e_d, lat);
        check("long_dr_out", 64'(dr_out), 64'hDEAD_BEEF);
        check("long_valid_cnt", 64'(v_d), 64'd1);
        check("long_err_cnt", 64'(e_d), 64'd0);

        // Reset in the middle of a shift discards the partial word
        start_shift(32'hFFFF_FFFF, "rstmid");
        shift_bits(64'h0000_0000_0000_FFFF, 16, -1, miso_word);
        rst      = 1'b1;
        shift_dr = 1'b0;
        spi_sck  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_dr_out", 64'(dr_out), 64'd0);
        check("rstmid_miso", 64'(spi_miso), 64'd0);
        do_update(v_d, e_d, lat);
        check("rstmid_err_cnt", 64'(e_d), 64'd1);
        check("rstmid_valid_cnt", 64'(v_d), 64'd0);
        check("rstmid_dr_out_after", 64'(dr_out), 64'd0);

        // update_dr raised inside the shift window is ignored
        v0 = valid_pulses;
        e0 = err_pulses;
        start_shift(32'h0, "updin");
        shift_bits(64'h0000_0000_600D_F00D, 32, 8, miso_word);
        end_shift("updin");
        check("updin_valid_none", 64'(valid_pulses - v0), 64'd0);
        check("updin_err_none", 64'(err_pulses - e0), 64'd0);
        do_update(v_d, e_d, lat);
        check("updin_dr_out", 64'(dr_out), 64'h600D_F00D);
        check("updin_valid_cnt", 64'(v_d), 64'd1);
        check("updin_err_cnt", 64'(e_d), 64'd0);

        check("valid_err_exclusive", 64'(both_high), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbg_dr_shift.md
# dbg_dr_shift

Fabric-side debug data-register shifter between the MSS SPI_0 master and the SchoolMIPS core debug port. It turns MSS SPI traffic (SCK/DO plus GPIO-driven shift/update strobes) into a parallel 32-bit debug word with a one-cycle valid strobe. In the same shift it returns a captured core value on the SPI data-in line. Everything runs on the fabric clock; SPI-side inputs are asynchronous and are resynchronised internally.

## Interface
- `WIDTH`, 32: debug data register length in bits.
- `clk`  in  1  fabric clock (RC oscillator domain, at least 4x SCK frequency).
- `rst`  in  1  synchronous active-high reset.
- `spi_sck`  in  1  SPI clock from the MSS, asynchronous, idle low (mode 0).
- `spi_mosi`  in  1  SPI data from the MSS, MSB first.
- `spi_miso`  out  WIDTH-independent 1  SPI data to the MSS, MSB of the shift register.
- `shift_dr`  in  1  GPIO strobe, asynchronous; high for the whole shift window.
- `update_dr`  in  1  GPIO strobe, asynchronous; a rising edge commits the shifted word.
- `capture_data`  in  WIDTH  core value loaded at the start of a shift window.
- `dr_out`  out  WIDTH  last committed word.
- `dr_valid`  out  1  one-cycle pulse when `dr_out` updates.
- `dr_err`  out  1  one-cycle pulse when an update is rejected.
- `busy`  out  1  high while in SHIFT.

## Operation
- Input conditioning:
  - `spi_sck`, `spi_mosi`, `shift_dr` and `update_dr` each pass through a 2-flop synchronizer.
  - One further register per line provides edge detection (rise = sync & ~prev).
- State machine with states IDLE, SHIFT and UPDATE:
  - IDLE -> SHIFT on a `shift_dr` rise. On entry: shreg <= `capture_data`, bitcnt <= 0.
  - In SHIFT, on each `sck` rise: shreg <= {shreg[WIDTH-2:0], mosi_sync}. bitcnt increments and saturates at WIDTH.
  - SHIFT -> IDLE on a `shift_dr` fall.
  - IDLE -> UPDATE on an `update_dr` rise.
  - UPDATE -> IDLE unconditionally after one cycle. If bitcnt == WIDTH: `dr_out` <= shreg and `dr_valid` pulses. Otherwise `dr_err` pulses and `dr_out` holds.
  - An `update_dr` rise while in SHIFT is ignored and raises no error.
  - `sck` edges outside SHIFT are ignored.
- Over-length shift (more than WIDTH edges): bits keep shifting through and bitcnt stays at WIDTH, so the last WIDTH bits commit.
- `spi_miso` = shreg[WIDTH-1], combinational from the register. It changes within 4 clk of an `sck` rise, so it is stable before the next `sck` rise at the 4x ratio.
- bitcnt is $clog2(WIDTH+1) bits wide.

## Timing
- Reset values: `dr_out`=0, `dr_valid`=0, `dr_err`=0, `busy`=0, shreg=0, `spi_miso`=0, bitcnt=0, state IDLE. Synchronizer flops also reset to 0.
- Pin-to-action latency (with sync):
  - A pin edge is acted on at the 3rd `clk` rising edge after it (2 sync + 1 edge register).
  - `dr_valid` asserts 4 clk after the `update_dr` pin rise (edge detected, then UPDATE state).
- `busy` rises in the cycle after the `shift_dr` rise is detected, and falls the cycle after its fall is detected.
- If `shift_dr` falls and `sck` rises in the same cycle, the shift is applied first, then the machine goes to IDLE.
- A `shift_dr` rise and an `update_dr` rise detected together: the shift takes priority and the update is dropped.
- Reset asserted mid-SHIFT: all state returns to reset values in the next cycle and the partial word is discarded. A later `update_dr` without a fresh shift gives `dr_err`.
- `dr_valid` and `dr_err` are never high together.

## Configuration
- `DBG_DR_SYNC_EN` defined: 2-flop synchronizers present, with the latencies above.
- `DBG_DR_SYNC_EN` undefined: the synchronizers are removed and the edge-detect register samples the pins directly. For use when the strobes are already in the `clk` domain. All latencies drop by 2 clk; behaviour is otherwise identical.

## Test plan
- Reset, then idle: all outputs 0, with no pulses for 100 cycles while `sck` toggles and `shift_dr`=0.
- `capture_data`=0xCAFE_F00D, shift in 32 bits of 0x1234_5678, then update. Required:
  - `spi_miso` presents 0xCAFEF00D MSB first.
  - `dr_out`=0x12345678 with a single `dr_valid` pulse 4 clk after the update rise.
- Shift 31 bits, then update: `dr_err` pulses, `dr_out` keeps its previous value, `dr_valid` stays 0.
- Shift 40 bits (0xAA followed by 0xDEADBEEF), then update: `dr_out`=0xDEADBEEF with `dr_valid`.
- Assert `rst` after 16 bits, then update without a new shift: `dr_err` pulses and `dr_out`=0.
- Raise `update_dr` during SHIFT: no `dr_valid` and no `dr_err`. After the shift completes, a normal update commits.
